tnn_feature_framer: RTL

Front-end stage for the 2-bit-input evolved classifiers (for example, breastcancer2b, 5 features × 2 bits). The block accepts raw 8-bit feature samples over a valid/ready stream and quantises each one to 2 bits using per-feature programmable thresholds. It assembles five quantised features into one frame, drives the combinational classifier's `input_a`..`input_e`, registers the classifier's 1-bit `cgp_out`, and returns the result over a valid/ready output stream.

---
 rtl/tnn_feature_framer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/tnn_feature_framer.sv
`default_nettype none
// ============================================================================
// Module   : tnn_feature_framer
// Purpose  : Front end for the 2-bit-input evolved classifiers. Raw 8-bit
//            samples arrive in feature order a..e. Each sample is quantised
//            to 2 bits against three programmable thresholds for its feature.
//            Five quantised features make one frame. The frame drives the
//            combinational classifier, and the registered class is returned
//            on a valid/ready stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   s_valid_i/s_ready_o : raw sample handshake; s_data_i = sample,
//                         s_last_i = last sample of a frame
//   cfg_we_i/addr/data  : threshold write, addr = 3*feature + level (0..14)
//   feat_a_o..feat_e_o  : quantised features to classifier input_a..input_e
//   cls_in_i            : classifier cgp_out[0]
//   m_valid_o/m_ready_i : result handshake; m_class_o = class,
//                         m_err_o = frame error flag
// Build option
//   TNN_FRAME_CHECK_EN  : enables the frame-length check (s_last_i, DRAIN
//                         state, m_err_o). If undefined, framing is by count
//                         only and m_err_o is tied to 0.
// ============================================================================
module tnn_feature_framer #(
    parameter int NFEAT = 5,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_last_i,
    input  logic          cfg_we_i,
    input  logic [3:0]    cfg_addr_i,
    input  logic [DW-1:0] cfg_data_i,
    output logic [1:0]    feat_a_o,
    output logic [1:0]    feat_b_o,
    output logic [1:0]    feat_c_o,
    output logic [1:0]    feat_d_o,
    output logic [1:0]    feat_e_o,
    input  logic          cls_in_i,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic          m_class_o,
    output logic          m_err_o
);

    localparam int       c_NTHR      = 3 * NFEAT;
    localparam bit [3:0] c_NTHR_4    = 4'(c_NTHR);
    localparam bit [2:0] c_LAST_IDX  = 3'(NFEAT - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EVAL    = 2'd1,
        ST_HOLD    = 2'd2
`ifdef TNN_FRAME_CHECK_EN
        ,ST_DRAIN  = 2'd3
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [1:0]    feat_q [NFEAT];
    logic [1:0]    feat_d [NFEAT];
    logic          class_q, class_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic [DW-1:0] thr_q [c_NTHR];

    logic          w_acc;
    logic [3:0]    w_base;
    logic [1:0]    w_q;

    // ------------------------------------------------------------------
    // Threshold bank: 3 levels per feature, defaults 64/128/192.
    // Same-cycle accepts see the pre-write value because the quantiser
    // reads the registered bank.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NFEAT; i++) begin
                thr_q[3*i]   <= DW'(64);
                thr_q[3*i+1] <= DW'(128);
                thr_q[3*i+2] <= DW'(192);
            end
        end else if (cfg_we_i && (cfg_addr_i < c_NTHR_4)) begin
            thr_q[cfg_addr_i] <= cfg_data_i;
        end
    end

    // Quantiser. Priority is t2 > t1 > t0. Monotonic order is not assumed.
    assign w_base = 4'(idx_q) * 4'd3;

    always_comb begin
        w_q = 2'd0;
        if (s_data_i >= thr_q[w_base + 4'd2]) begin
            w_q = 2'd3;
        end else if (s_data_i >= thr_q[w_base + 4'd1]) begin
            w_q = 2'd2;
        end else if (s_data_i >= thr_q[w_base]) begin
            w_q = 2'd1;
        end
    end

    // An accept is qualified by the registered ready, so it depends only
    // on state.
    assign w_acc = s_valid_i & s_ready_q;

`ifdef TNN_FRAME_CHECK_EN
    logic err_q, err_d;
    logic drain_q, drain_d;   // frame overran 5 samples: drain after EVAL
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        feat_d  = feat_q;
        class_d = class_q;
`ifdef TNN_FRAME_CHECK_EN
        err_d   = err_q;
        drain_d = drain_q;
`endif
        case (state_q)
            ST_COLLECT: begin
                if (w_acc) begin
`ifdef TNN_FRAME_CHECK_EN
                    if (s_last_i && (idx_q != c_LAST_IDX)) begin
                        // Short frame: drop it and report an error without
                        // evaluating the classifier.
                        state_d = ST_HOLD;
                        idx_d   = 3'd0;
                        class_d = 1'b0;
                        err_d   = 1'b1;
                    end else
`endif
                    begin
                        feat_d[idx_q] = w_q;
                        if (idx_q == c_LAST_IDX) begin
                            idx_d   = 3'd0;
                            state_d = ST_EVAL;
`ifdef TNN_FRAME_CHECK_EN
                            drain_d = ~s_last_i;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            ST_EVAL: begin
                class_d = cls_in_i;
`ifdef TNN_FRAME_CHECK_EN
                err_d   = 1'b0;
                state_d = drain_q ? ST_DRAIN : ST_HOLD;
`else
                state_d = ST_HOLD;
`endif
            end
            ST_HOLD: begin
                if (m_ready_i) begin
                    state_d = ST_COLLECT;
                end
            end
`ifdef TNN_FRAME_CHECK_EN
            ST_DRAIN: begin
                if (w_acc && s_last_i) begin
                    state_d = ST_HOLD;
                    class_d = 1'b0;
                    err_d   = 1'b1;
                    drain_d = 1'b0;
                end
            end
`endif
            default: state_d = ST_COLLECT;
        endcase

        // Handshake outputs are registered decodes of the next state.
        s_ready_d = (state_d == ST_COLLECT);
`ifdef TNN_FRAME_CHECK_EN
        if (state_d == ST_DRAIN) begin
            s_ready_d = 1'b1;
        end
`endif
        m_valid_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_COLLECT;
            idx_q     <= 3'd0;
            class_q   <= 1'b0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            for (int i = 0; i < NFEAT; i++) begin
                feat_q[i] <= 2'd0;
            end
`ifdef TNN_FRAME_CHECK_EN
            err_q     <= 1'b0;
            drain_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            class_q   <= class_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            feat_q    <= feat_d;
`ifdef TNN_FRAME_CHECK_EN
            err_q     <= err_d;
            drain_q   <= drain_d;
`endif
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_class_o = class_q;
    assign feat_a_o  = feat_q[0];
    assign feat_b_o  = feat_q[1];
    assign feat_c_o  = feat_q[2];
    assign feat_d_o  = feat_q[3];
    assign feat_e_o  = feat_q[4];

`ifdef TNN_FRAME_CHECK_EN
    assign m_err_o = err_q;
`else
    // Framing is by count only, so s_last_i is intentionally unused.
    logic w_unused;
    assign w_unused = s_last_i;
    assign m_err_o  = 1'b0;
`endif

endmodule
`default_nettype wire
